apb_master: RTL and testbench

// APB requester driving the two 16-bit register slaves (slave1/slave2) over a shared Paddr/Pwdata/Penable/Pwrite bus.

---
 rtl/apb_master.sv | 208 ++++++++++++++++++++
 tb/tb_apb_master.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// apb_master: APB requester for two 16-bit register slaves on a shared bus.
// Takes one read/write command at a time on a valid/ready handshake, runs the
// APB SETUP/ACCESS sequence, waits on the selected slave's Pready, and returns
// read data or completion on a one-cycle response strobe.
// Addresses >= NUM_REGS are answered locally with an error and no bus activity.
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase that has
// waited TIMEOUT_CYC cycles without Pready; the abort is reported as an error.
module apb_master #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned TIMEOUT_CYC = 32
) (
  input  logic              Pclk,
  input  logic              Prst_n,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_slv,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response side
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  // APB bus
  output logic              Psel1,
  output logic              Psel2,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  input  logic              Pready1,
  input  logic              Pready2,
  input  logic [DATA_W-1:0] Prdata1,
  input  logic [DATA_W-1:0] Prdata2
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_slv;
  logic              w_slv_nxt;

  logic              w_psel1_nxt;
  logic              w_psel2_nxt;
  logic              w_penable_nxt;
  logic              w_pwrite_nxt;
  logic [ADDR_W-1:0] w_paddr_nxt;
  logic [DATA_W-1:0] w_pwdata_nxt;
  logic              w_rsp_valid_nxt;
  logic [DATA_W-1:0] w_rsp_rdata_nxt;
  logic              w_rsp_err_nxt;

  logic              w_accept;
  logic              w_addr_ok;
  logic              w_pready;
  logic [DATA_W-1:0] w_prdata;

  // Ready only when idle and not still presenting the previous response.
  assign cmd_ready = (r_state == S_IDLE) && !rsp_valid;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_addr_ok = (32'(cmd_addr) < NUM_REGS);

  // Only the selected slave's ready/data matter; the other slave is ignored.
  assign w_pready  = r_slv ? Pready2 : Pready1;
  assign w_prdata  = r_slv ? Prdata2 : Prdata1;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TCNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TCNT_W-1:0] r_tcnt;
  logic [TCNT_W-1:0] w_tcnt_nxt;
  logic              w_tmo;

  // Limit hit when this not-ready cycle would be the TIMEOUT_CYC-th one.
  assign w_tmo = (r_tcnt == TCNT_W'(TIMEOUT_CYC - 1));

  // ACCESS wait-cycle counter.
  always_ff @(posedge Pclk or negedge Prst_n) begin
    if (!Prst_n) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= w_tcnt_nxt;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYC == 0);
`endif

  // State register.
  always_ff @(posedge Pclk or negedge Prst_n) begin
    if (!Prst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output logic; bus fields hold unless changed below.
  always_comb begin
    w_state_nxt     = r_state;
    w_slv_nxt       = r_slv;
    w_psel1_nxt     = Psel1;
    w_psel2_nxt     = Psel2;
    w_penable_nxt   = Penable;
    w_pwrite_nxt    = Pwrite;
    w_paddr_nxt     = Paddr;
    w_pwdata_nxt    = Pwdata;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = '0;
    w_rsp_err_nxt   = 1'b0;
`ifdef APB_TIMEOUT_EN
    w_tcnt_nxt      = r_tcnt;
`endif

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_addr_ok) begin
            w_state_nxt   = S_SETUP;
            w_slv_nxt     = cmd_slv;
            w_psel1_nxt   = !cmd_slv;
            w_psel2_nxt   = cmd_slv;
            w_penable_nxt = 1'b0;
            w_pwrite_nxt  = cmd_write;
            w_paddr_nxt   = cmd_addr;
            w_pwdata_nxt  = cmd_wdata;
          end else begin
            // Out-of-range register: answer locally, bus untouched.
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
          end
        end
      end

      S_SETUP: begin
        w_penable_nxt = 1'b1;
        w_state_nxt   = S_ACCESS;
`ifdef APB_TIMEOUT_EN
        w_tcnt_nxt    = '0;
`endif
      end

      S_ACCESS: begin
        if (w_pready) begin
          w_psel1_nxt     = 1'b0;
          w_psel2_nxt     = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = Pwrite ? '0 : w_prdata;
          w_state_nxt     = S_IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (w_tmo) begin
          w_psel1_nxt     = 1'b0;
          w_psel2_nxt     = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_state_nxt     = S_IDLE;
        end else begin
          w_tcnt_nxt = r_tcnt + TCNT_W'(1);
        end
`endif
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered bus and response outputs.
  always_ff @(posedge Pclk or negedge Prst_n) begin
    if (!Prst_n) begin
      r_slv     <= 1'b0;
      Psel1     <= 1'b0;
      Psel2     <= 1'b0;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
      Paddr     <= '0;
      Pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      r_slv     <= w_slv_nxt;
      Psel1     <= w_psel1_nxt;
      Psel2     <= w_psel2_nxt;
      Penable   <= w_penable_nxt;
      Pwrite    <= w_pwrite_nxt;
      Paddr     <= w_paddr_nxt;
      Pwdata    <= w_pwdata_nxt;
      rsp_valid <= w_rsp_valid_nxt;
      rsp_rdata <= w_rsp_rdata_nxt;
      rsp_err   <= w_rsp_err_nxt;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized bench for apb_master with a transaction-level
// reference model (command queue, slave register arrays, per-command wait
// counts) checked against the DUT outputs every cycle, plus directed cases.
module tb_apb_master;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 4;

  logic              Pclk;
  logic              Prst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic              cmd_slv;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              Psel1;
  logic              Psel2;
  logic              Penable;
  logic              Pwrite;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata;
  logic              Pready1;
  logic              Pready2;
  logic [DATA_W-1:0] Prdata1;
  logic [DATA_W-1:0] Prdata2;

  apb_master #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .TIMEOUT_CYC(32)
  ) dut (
    .Pclk(Pclk), .Prst_n(Prst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_slv(cmd_slv), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Psel1(Psel1), .Psel2(Psel2), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata),
    .Pready1(Pready1), .Pready2(Pready2), .Prdata1(Prdata1), .Prdata2(Prdata2)
  );

  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  typedef struct {
    bit          wr;
    bit          slv;
    int          addr;
    logic [15:0] wdata;
    int          w;      // not-ready ACCESS cycles the slave inserts
  } cmd_t;

  cmd_t        cmd_q[$];
  logic [15:0] mem [0:1][0:3];

  // Reference model: one in-flight transfer with its age in cycles since accept.
  bit          m_busy;
  bit          m_slv;
  bit          m_wr;
  int          m_addr;
  logic [15:0] m_wdata;
  int          m_age;
  int          m_wait_left;
  bit          m_rsp;
  logic [15:0] m_rdata;
  bit          m_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int unsigned gap_pct = 0;
  bit          rst_req = 0;

  // Segment observations of the DUT for hand-computed expectations.
  int          cnt_psel1, cnt_psel2, cnt_pen, n_rsp, n_acc_dut;
  logic [15:0] last_rdata;
  logic        last_err;
  int          rsp_cyc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h want 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic push(input bit wr, input bit slv, input int addr,
                      input logic [15:0] wdata, input int w);
    cmd_t c;
    c.wr = wr; c.slv = slv; c.addr = addr; c.wdata = wdata; c.w = w;
    cmd_q.push_back(c);
  endtask

  task automatic seg_clear();
    cnt_psel1 = 0; cnt_psel2 = 0; cnt_pen = 0; n_rsp = 0; n_acc_dut = 0;
    last_rdata = '0; last_err = 1'b0;
    rsp_cyc_q.delete();
  endtask

  // One clock: compare at negedge, drive inputs, advance model to next edge.
  task automatic step();
    bit          sel_rdy;
    bit          r1, r2;
    bit          nrsp;
    logic [15:0] d1, d2;
    cmd_t        c;
    @(negedge Pclk);
    cyc++;
    if (Psel1)   cnt_psel1++;
    if (Psel2)   cnt_psel2++;
    if (Penable) cnt_pen++;
    if (rsp_valid) begin
      n_rsp++; last_rdata = rsp_rdata; last_err = rsp_err; rsp_cyc_q.push_back(cyc);
    end

    chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy && !m_rsp));
    chk("Psel1",     32'(Psel1),     32'(m_busy && !m_slv));
    chk("Psel2",     32'(Psel2),     32'(m_busy && m_slv));
    chk("Penable",   32'(Penable),   32'(m_busy && (m_age >= 1)));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
    if (m_busy) begin
      chk("Paddr",  32'(Paddr),  32'(m_addr));
      chk("Pwrite", 32'(Pwrite), 32'(m_wr));
      chk("Pwdata", 32'(Pwdata), 32'(m_wdata));
    end
    if (m_rsp) begin
      chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
      chk("rsp_err",   32'(rsp_err),   32'(m_err));
    end

    if (rst_req && m_busy && m_age == 2) begin
      rst_req   = 0;
      Prst_n    = 1'b0;
      cmd_valid = 1'b0;
      #1;
      chk("rst_Psel2",     32'(Psel2),     0);
      chk("rst_Penable",   32'(Penable),   0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      m_busy = 0;
      m_rsp  = 0;
      return;
    end

    Prst_n = 1'b1;
    if (cmd_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
      cmd_valid = 1'b1;
      cmd_write = cmd_q[0].wr;
      cmd_slv   = cmd_q[0].slv;
      cmd_addr  = 3'(cmd_q[0].addr);
      cmd_wdata = cmd_q[0].wdata;
    end else begin
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_slv   = 1'($urandom);
      cmd_addr  = 3'($urandom);
      cmd_wdata = 16'($urandom);
    end
    if (cmd_valid && cmd_ready) n_acc_dut++;

    d1 = 16'($urandom); d2 = 16'($urandom);
    r1 = 1'($urandom);  r2 = 1'($urandom);
    sel_rdy = 0;
    if (m_busy && m_age >= 1) begin
      sel_rdy = (m_wait_left == 0);
      if (m_slv) begin
        r2 = sel_rdy;
        if (sel_rdy && !m_wr) d2 = mem[1][m_addr];
      end else begin
        r1 = sel_rdy;
        if (sel_rdy && !m_wr) d1 = mem[0][m_addr];
      end
    end
    Pready1 = r1; Pready2 = r2; Prdata1 = d1; Prdata2 = d2;

    nrsp = 0;
    if (m_busy) begin
      if (m_age >= 1 && sel_rdy) begin
        m_busy = 0;
        nrsp   = 1;
        m_err  = 0;
        if (m_wr) begin
          m_rdata = '0;
          mem[m_slv][m_addr] = m_wdata;
        end else begin
          m_rdata = mem[m_slv][m_addr];
        end
      end else begin
        if (m_age >= 1) m_wait_left--;
        m_age++;
      end
    end else if (cmd_valid && !m_rsp) begin
      c = cmd_q.pop_front();
      if (c.addr >= int'(NUM_REGS)) begin
        nrsp = 1; m_err = 1; m_rdata = '0;
      end else begin
        m_busy = 1; m_slv = c.slv; m_wr = c.wr; m_addr = c.addr;
        m_wdata = c.wdata; m_age = 0; m_wait_left = c.w;
      end
    end
    m_rsp = nrsp;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((cmd_q.size() > 0 || m_busy || m_rsp) && n < budget);
    chk("drain_budget", 32'(cmd_q.size() > 0 || m_busy || m_rsp), 0);
  endtask

  initial begin
    Prst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_slv = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; Pready1 = 1'b0; Pready2 = 1'b0;
    Prdata1 = '0; Prdata2 = '0;
    m_busy = 0; m_rsp = 0; m_age = 0; m_wait_left = 0;
    m_slv = 0; m_wr = 0; m_addr = 0; m_wdata = '0; m_rdata = '0; m_err = 0;
    foreach (mem[s, a]) mem[s][a] = 16'($urandom);
    seg_clear();

    @(negedge Pclk);
    @(negedge Pclk);
    chk("reset_Psel1",     32'(Psel1),     0);
    chk("reset_Psel2",     32'(Psel2),     0);
    chk("reset_Penable",   32'(Penable),   0);
    chk("reset_Pwrite",    32'(Pwrite),    0);
    chk("reset_Paddr",     32'(Paddr),     0);
    chk("reset_Pwdata",    32'(Pwdata),    0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_rdata", 32'(rsp_rdata), 0);
    chk("reset_rsp_err",   32'(rsp_err),   0);
    chk("reset_cmd_ready", 32'(cmd_ready), 1);

    // Write slave2 reg2 with immediate ready, then read it back.
    seg_clear();
    push(1, 1, 2, 16'h00A5, 0);
    drain(50);
    chk("t1_psel2_cycles",   32'(cnt_psel2), 2);
    chk("t1_penable_cycles", 32'(cnt_pen),   1);
    chk("t1_rsp_count",      32'(n_rsp),     1);
    chk("t1_wr_err",         32'(last_err),  0);
    seg_clear();
    push(0, 1, 2, 16'h0000, 0);
    drain(50);
    chk("t1_rd_data", 32'(last_rdata), 32'h00A5);
    chk("t1_rd_err",  32'(last_err),   0);

    // Write slave1 reg1 with three wait states, then read back.
    seg_clear();
    push(1, 0, 1, 16'h1234, 3);
    drain(50);
    chk("t2_psel2_cycles",   32'(cnt_psel2), 0);
    chk("t2_psel1_cycles",   32'(cnt_psel1), 5);
    chk("t2_penable_cycles", 32'(cnt_pen),   4);
    chk("t2_rsp_count",      32'(n_rsp),     1);
    seg_clear();
    push(0, 0, 1, 16'h0000, 1);
    drain(50);
    chk("t2_rd_data", 32'(last_rdata), 32'h1234);

    // Out-of-range address.
    seg_clear();
    push(0, 0, 5, 16'h0000, 0);
    drain(50);
    chk("t3_psel_cycles",    32'(cnt_psel1 + cnt_psel2), 0);
    chk("t3_penable_cycles", 32'(cnt_pen),    0);
    chk("t3_rsp_count",      32'(n_rsp),      1);
    chk("t3_err",            32'(last_err),   1);
    chk("t3_rdata",          32'(last_rdata), 0);

    // Three back-to-back commands with cmd_valid held high.
    seg_clear();
    gap_pct = 0;
    push(1, 0, 0, 16'h1111, 0);
    push(0, 0, 0, 16'h0000, 0);
    push(1, 1, 3, 16'hBEEF, 0);
    drain(60);
    chk("t6_accepts",   32'(n_acc_dut), 3);
    chk("t6_rsp_count", 32'(n_rsp),     3);
    if (rsp_cyc_q.size() == 3) begin
      chk("t6_rsp_gap1", 32'(rsp_cyc_q[1] - rsp_cyc_q[0]), 4);
      chk("t6_rsp_gap2", 32'(rsp_cyc_q[2] - rsp_cyc_q[1]), 4);
    end

    // Reset asserted in the middle of ACCESS of a slave2 read.
    seg_clear();
    rst_req = 1;
    push(0, 1, 3, 16'h0000, 50);
    drain(60);
    step();
    step();
    chk("t4_no_rsp",    32'(n_rsp),     0);
    chk("t4_cmd_ready", 32'(cmd_ready), 1);
    chk("t4_psel2",     32'(Psel2),     0);

    // Randomized traffic with gaps, wait states and out-of-range addresses.
    gap_pct = 30;
    for (int i = 0; i < 250; i++) begin
      push(1'($urandom), 1'($urandom),
           ($urandom_range(0, 5) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3)),
           16'($urandom),
           ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 10)) : int'($urandom_range(0, 2)));
    end
    drain(6000);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
